// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared FSM state type and default sizes for the chain loader
package ccff_loader_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_WORD, ST_SHIFT, ST_FINISH} ccff_ld_state_t;
  localparam int CCFF_CHAIN_LEN_DEF = 16;
  localparam int CCFF_WORD_W_DEF    = 8;
endpackage

// File: rtl/ccff_shadow_chk.sv
// ccff_shadow_chk: shadow copy of the configuration chain that flags tail mismatches
module ccff_shadow_chk #(
  parameter int CHAIN_LEN = 16
) (
  input  logic prog_clk,
  input  logic prog_reset,
  input  logic i_clr,
  input  logic i_shift_en,
  input  logic i_head,
  input  logic i_tail,
  output logic o_err
);
  logic [CHAIN_LEN-1:0] r_shadow;
  logic                 r_err;
  // mirror every chain shift; the bit leaving the shadow must appear on the tail
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_shadow <= '0;
      r_err    <= 1'b0;
    end else begin
      if (i_shift_en) r_shadow <= {r_shadow[CHAIN_LEN-2:0], i_head};
      if (i_clr) r_err <= 1'b0;
      else if (i_shift_en && (i_tail != r_shadow[CHAIN_LEN-1])) r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises handshaked config words LSB-first into a ccff chain (optional tail check: CCFF_TAIL_CHECK_EN)
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter  int WORD_W    = CCFF_WORD_W_DEF,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int BIT_W = $clog2(WORD_W + 1);
  ccff_ld_state_t    r_state;
  logic [CNT_W-1:0]  r_total;
  logic [BIT_W-1:0]  r_bit;
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  w_total_nxt;
  logic [BIT_W-1:0]  w_bit_nxt;
  assign w_total_nxt = r_total + CNT_W'(1);
  assign w_bit_nxt   = r_bit + BIT_W'(1);
  // load sequencer: the chain limit wins over the word boundary, discarding leftover word bits
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_state <= ST_IDLE;
      r_total <= '0;
      r_bit   <= '0;
      r_word  <= '0;
    end else if (abort && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_total <= '0;
          if (start) r_state <= ST_WAIT_WORD;
        end
        ST_WAIT_WORD: if (cfg_valid) begin
          r_word  <= cfg_data;
          r_bit   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_word  <= r_word >> 1;
          r_total <= w_total_nxt;
          r_bit   <= w_bit_nxt;
          r_state <= (w_total_nxt == CNT_W'(CHAIN_LEN)) ? ST_FINISH :
                     (w_bit_nxt == BIT_W'(WORD_W))      ? ST_WAIT_WORD : ST_SHIFT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  // outputs decode the registered state; an abort suppresses a pending done
  always_comb begin
    cfg_ready     = (r_state == ST_WAIT_WORD);
    ccff_shift_en = (r_state == ST_SHIFT);
    ccff_head     = (r_state == ST_SHIFT) ? r_word[0] : 1'b0;
    busy          = (r_state == ST_WAIT_WORD) || (r_state == ST_SHIFT);
    done          = (r_state == ST_FINISH) && !abort;
  end
`ifdef CCFF_TAIL_CHECK_EN
  logic w_start_acc;
  assign w_start_acc = (r_state == ST_IDLE) && start;
  ccff_shadow_chk #(.CHAIN_LEN(CHAIN_LEN)) u_shadow_chk (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .i_clr      (w_start_acc),
    .i_shift_en (ccff_shift_en),
    .i_head     (ccff_head),
    .i_tail     (ccff_tail),
    .o_err      (err)
  );
`else
  logic w_unused;
  assign w_unused = ccff_tail;
  assign err      = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of the chain loader at CHAIN_LEN 16 and 12
module tb_ccff_chain_loader;
  logic       prog_clk = 1'b0;
  logic       prog_reset = 1'b0;
  logic       start16 = 1'b0, start12 = 1'b0, abort = 1'b0, cfg_valid = 1'b0, force_tail = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       rdy16, head16, se16, busy16, done16, err16, tail16;
  logic       rdy12, head12, se12, busy12, done12, err12, tail12;
  logic [15:0] ch16;
  logic [11:0] ch12;
  int n_vec = 0, n_miss = 0;
  int o_shifts, o_dones, o_done_cyc, o_last_se;
  logic [15:0] o_heads;
  logic o_busy_ab, o_se_ab, o_busy_c1, o_rdy_c1, o_busy_done;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start16), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy16), .ccff_head(head16),
    .ccff_shift_en(se16), .ccff_tail(tail16), .busy(busy16), .done(done16), .err(err16));

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start12), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy12), .ccff_head(head12),
    .ccff_shift_en(se12), .ccff_tail(tail12), .busy(busy12), .done(done12), .err(err12));

  always @(posedge prog_clk or negedge prog_reset)
    if (!prog_reset) begin ch16 <= '0; ch12 <= '0; end
    else begin
      if (se16) ch16 <= {ch16[14:0], head16};
      if (se12) ch12 <= {ch12[10:0], head12};
    end
  assign tail16 = force_tail ? 1'b1 : ch16[15];
  assign tail12 = force_tail ? 1'b1 : ch12[11];

  task automatic run_load(input bit sel12, input logic [7:0] w0, input logic [7:0] w1,
                          input int gap, input int abort_at);
    int idx = 0, waited = 0, ab_cyc = -1;
    logic r, s, h, d, b;
    o_shifts = 0; o_dones = 0; o_done_cyc = -1; o_last_se = -1; o_heads = '0;
    o_busy_ab = 1'bx; o_se_ab = 1'bx; o_busy_c1 = 1'bx; o_rdy_c1 = 1'bx; o_busy_done = 1'bx;
    @(negedge prog_clk);
    if (sel12) start12 = 1'b1; else start16 = 1'b1;
    cfg_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge prog_clk);
      start12 = 1'b0; start16 = 1'b0; abort = 1'b0;
      r = sel12 ? rdy12 : rdy16;   s = sel12 ? se12 : se16;   h = sel12 ? head12 : head16;
      d = sel12 ? done12 : done16; b = sel12 ? busy12 : busy16;
      if (c == 1) begin o_busy_c1 = b; o_rdy_c1 = r; end
      if (c == ab_cyc) begin o_busy_ab = b; o_se_ab = s; end
      if (s) begin
        if (o_shifts < 16) o_heads[o_shifts] = h;
        o_shifts++; o_last_se = c;
        if (o_shifts == abort_at) begin abort = 1'b1; ab_cyc = c + 1; end
      end
      if (d) begin o_dones++; o_done_cyc = c; o_busy_done = b; end
      cfg_valid = (idx == 0) || (idx == 1 && waited >= gap);
      cfg_data  = (idx == 0) ? w0 : w1;
      if (idx == 1 && r && !cfg_valid) waited++;
      if (r && cfg_valid) idx++;
      if (idx >= 2 && !r) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge prog_clk); prog_reset = 1'b0;
    @(negedge prog_clk); prog_reset = 1'b1;
  endtask

  task automatic test_reset();
    prog_reset = 1'b0;
    repeat (2) @(negedge prog_clk);
    n_vec++; if ({rdy16, head16, se16, busy16, done16, err16} !== 6'b0) begin n_miss++; $display("FAIL reset16: got %b want 000000", {rdy16, head16, se16, busy16, done16, err16}); end
    n_vec++; if ({rdy12, head12, se12, busy12, done12, err12} !== 6'b0) begin n_miss++; $display("FAIL reset12: got %b want 000000", {rdy12, head12, se12, busy12, done12, err12}); end
    prog_reset = 1'b1;
  endtask

  task automatic test_basic_load();
    run_load(1'b0, 8'hA5, 8'h3C, 0, 0);
    n_vec++; if (o_busy_c1 !== 1'b1 || o_rdy_c1 !== 1'b1) begin n_miss++; $display("FAIL basic_busy_ready: got %b%b want 11", o_busy_c1, o_rdy_c1); end
    n_vec++; if (o_heads !== 16'h3CA5) begin n_miss++; $display("FAIL basic_heads: got %h want 3ca5", o_heads); end
    n_vec++; if (o_shifts !== 16) begin n_miss++; $display("FAIL basic_shifts: got %0d want 16", o_shifts); end
    n_vec++; if (o_dones !== 1 || o_done_cyc !== 19) begin n_miss++; $display("FAIL basic_done: got %0d@%0d want 1@19", o_dones, o_done_cyc); end
    n_vec++; if (o_last_se !== 18) begin n_miss++; $display("FAIL basic_last_shift: got %0d want 18", o_last_se); end
    n_vec++; if (o_busy_done !== 1'b0) begin n_miss++; $display("FAIL basic_busy_at_done: got %b want 0", o_busy_done); end
  endtask

  task automatic test_stall();
    run_load(1'b0, 8'hA5, 8'h3C, 5, 0);
    n_vec++; if (o_heads !== 16'h3CA5) begin n_miss++; $display("FAIL stall_heads: got %h want 3ca5", o_heads); end
    n_vec++; if (o_shifts !== 16) begin n_miss++; $display("FAIL stall_shifts: got %0d want 16", o_shifts); end
    n_vec++; if (o_dones !== 1 || o_done_cyc !== 24) begin n_miss++; $display("FAIL stall_done: got %0d@%0d want 1@24", o_dones, o_done_cyc); end
  endtask

  task automatic test_short_chain();
    run_load(1'b1, 8'hFF, 8'h0F, 0, 0);
    n_vec++; if (o_shifts !== 12) begin n_miss++; $display("FAIL short_shifts: got %0d want 12", o_shifts); end
    n_vec++; if (o_heads !== 16'h0FFF) begin n_miss++; $display("FAIL short_heads: got %h want 0fff", o_heads); end
    n_vec++; if (o_dones !== 1 || o_done_cyc !== 15) begin n_miss++; $display("FAIL short_done: got %0d@%0d want 1@15", o_dones, o_done_cyc); end
  endtask

  task automatic test_abort();
    run_load(1'b0, 8'hA5, 8'h3C, 0, 5);
    n_vec++; if (o_busy_ab !== 1'b0 || o_se_ab !== 1'b0) begin n_miss++; $display("FAIL abort_after: got busy=%b se=%b want 0 0", o_busy_ab, o_se_ab); end
    n_vec++; if (o_shifts !== 5) begin n_miss++; $display("FAIL abort_shifts: got %0d want 5", o_shifts); end
    n_vec++; if (o_dones !== 0) begin n_miss++; $display("FAIL abort_done: got %0d want 0", o_dones); end
    run_load(1'b0, 8'h5A, 8'hC3, 0, 0);
    n_vec++; if (o_shifts !== 16 || o_heads !== 16'hC35A) begin n_miss++; $display("FAIL abort_reload: got %0d/%h want 16/c35a", o_shifts, o_heads); end
    n_vec++; if (o_dones !== 1) begin n_miss++; $display("FAIL abort_reload_done: got %0d want 1", o_dones); end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge prog_clk); start16 = 1'b1;
    @(negedge prog_clk); start16 = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hA5;
    @(negedge prog_clk);
    n_vec++; if (se16 !== 1'b1 || head16 !== 1'b1) begin n_miss++; $display("FAIL rst_mid_pre: got se=%b head=%b want 1 1", se16, head16); end
    #2 prog_reset = 1'b0;
    #1;
    n_vec++; if ({rdy16, head16, se16, busy16, done16, err16} !== 6'b0) begin n_miss++; $display("FAIL rst_mid_async: got %b want 000000", {rdy16, head16, se16, busy16, done16, err16}); end
    @(negedge prog_clk); prog_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      n_vec++; if ({rdy16, se16, busy16} !== 3'b0) begin n_miss++; $display("FAIL rst_mid_idle%0d: got %b want 000", i, {rdy16, se16, busy16}); end
    end
    cfg_valid = 1'b0;
  endtask

`ifdef CCFF_TAIL_CHECK_EN
  task automatic test_tail_check();
    do_reset();
    run_load(1'b0, 8'hA5, 8'h3C, 0, 0);
    n_vec++; if (err16 !== 1'b0) begin n_miss++; $display("FAIL tail_ok1: got %b want 0", err16); end
    run_load(1'b0, 8'h00, 8'h00, 0, 0);
    n_vec++; if (err16 !== 1'b0) begin n_miss++; $display("FAIL tail_ok2: got %b want 0", err16); end
    do_reset();
    force_tail = 1'b1;
    run_load(1'b0, 8'hA5, 8'h3C, 0, 0);
    force_tail = 1'b0;
    n_vec++; if (err16 !== 1'b1) begin n_miss++; $display("FAIL tail_forced: got %b want 1", err16); end
    @(negedge prog_clk);
    n_vec++; if (err16 !== 1'b1) begin n_miss++; $display("FAIL tail_sticky: got %b want 1", err16); end
    start16 = 1'b1;
    @(negedge prog_clk); start16 = 1'b0;
    n_vec++; if (err16 !== 1'b0) begin n_miss++; $display("FAIL tail_clear: got %b want 0", err16); end
    abort = 1'b1;
    @(negedge prog_clk); abort = 1'b0;
  endtask
`else
  task automatic test_tail_check();
    force_tail = 1'b1;
    run_load(1'b0, 8'hA5, 8'h3C, 0, 0);
    force_tail = 1'b0;
    n_vec++; if (err16 !== 1'b0 || err12 !== 1'b0) begin n_miss++; $display("FAIL err_tied: got %b%b want 00", err16, err12); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_short_chain();
    test_abort();
    test_reset_mid_shift();
    test_tail_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
Sequencer that streams a configuration bitstream into a connection-block configuration chain, such as a chain of four 4-bit mux memories.
- Accepts parallel words over a valid/ready handshake.
- Serialises each word LSB-first onto ccff_head.
- Asserts a shift enable for exactly CHAIN_LEN cycles, then reports completion.
- Sits between the top-level programming interface and the ccff_head/ccff_tail ends of one tile's chain.

Parameters:
CHAIN_LEN, 16, number of configuration flip-flops in the chain (4 muxes x 4 SRAM bits).
WORD_W, 8, width of each incoming configuration word.
CNT_W, $clog2(CHAIN_LEN+1), width of the total-bit counter (derived; not overridden).

Ports:
prog_clk  in  1  programming clock; all state is updated on its rising edge.
prog_reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a load; ignored while busy=1.
abort  in  1  synchronous; returns the FSM to IDLE.
cfg_data  in  WORD_W  configuration word.
cfg_valid  in  1  cfg_data is valid.
cfg_ready  out  1  loader can accept a word.
ccff_head  out  1  serial bit into the chain.
ccff_shift_en  out  1  chain advances one bit this cycle (clock-enable for chain).
ccff_tail  in  1  serial bit out of the chain's far end.
busy  out  1  a load is in progress.
done  out  1  one-cycle pulse after the final shift.
err  out  1  tail-check mismatch; sticky. Constant 0 without the optional feature.

Behaviour:
- Reset (prog_reset=0, asynchronous):
  - FSM to IDLE.
  - Counters and word shift register cleared.
  - cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, err=0.
- States: IDLE, WAIT_WORD, SHIFT, FINISH.
- IDLE:
  - start=1 moves to WAIT_WORD.
  - Total-bit counter cleared; err cleared.
  - busy=1 from the next cycle.
- WAIT_WORD:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready: cfg_data is latched into the word register, word-bit counter=0, next state SHIFT.
  - The first shift happens the cycle after acceptance.
  - No shift occurs while waiting, so input stalls are legal at any length.
- SHIFT (combinational outputs from registered state):
  - ccff_shift_en=1 and ccff_head=word_reg[0] every cycle.
  - word_reg shifts right; both counters increment.
  - cfg_ready=0.
  - Exit conditions, checked in this order:
    - Total-bit counter reaches CHAIN_LEN: go to FINISH. Any remaining bits of the current word are discarded.
    - Else word-bit counter reaches WORD_W: go to WAIT_WORD.
    - Else stay in SHIFT.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Outside SHIFT: ccff_shift_en=0 and ccff_head=0.
- Words required per load: ceil(CHAIN_LEN/WORD_W).
- Shift enables per load: exactly CHAIN_LEN, never more.
- abort=1 in any non-IDLE state:
  - Next state IDLE; busy=0; done not asserted.
  - A partially shifted chain is left as-is.
  - abort overrides start and cfg_valid in the same cycle.
- start while busy is ignored.
- Reset mid-load: immediate return to IDLE.
- Minimum load time: one cycle per word acceptance plus CHAIN_LEN shift cycles plus the FINISH cycle.

Optional Feature:
CCFF_TAIL_CHECK_EN
- Enabled:
  - A CHAIN_LEN-bit shadow shift register models the chain.
  - It resets to 0 with prog_reset, matching the chain's own reset.
  - It shifts ccff_head in on every ccff_shift_en.
  - On each shift, ccff_tail must equal the shadow's oldest bit. A mismatch sets err, sticky until the next accepted start.
  - Because the shadow tracks every shift, it stays accurate across aborts.
- Disabled: no shadow register; err tied to 0; ccff_tail unused.

Decomposition:
- Shared package ccff_loader_pkg:
  - FSM state enum ccff_ld_state_t.
  - Default constants CCFF_CHAIN_LEN_DEF=16 and CCFF_WORD_W_DEF=8.
- One sub-module, ccff_shadow_chk: the shadow register and comparator, instantiated only under CCFF_TAIL_CHECK_EN.

Test Plan:
1. CHAIN_LEN=16, WORD_W=8; start, then words 0xA5 and 0x3C with valid held high.
   - ccff_head=1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 across 16 shift cycles.
   - One idle cycle between the two bursts (second word acceptance).
   - done pulses once, on the cycle after the 16th shift.
2. Same words, but cfg_valid for the second word delayed 5 cycles → ccff_shift_en stays 0 during the gap; total shift count is still exactly 16.
3. CHAIN_LEN=12, WORD_W=8; words 0xFF and 0x0F → 12 shifts, all head bits 1; the upper 4 bits of word 2 are never driven; done follows.
4. abort asserted after the 5th shift → next cycle busy=0, shift_en=0, no done pulse. A new start performs a full 16-shift load.
5. CCFF_TAIL_CHECK_EN, chain model connected:
   - Load 0xA5,0x3C, then reload 0x00,0x00 → ccff_tail matches the shadow, err=0.
   - Force ccff_tail=1 during the first load after reset → err=1, held until the next start.
6. Assert reset mid-SHIFT (prog_reset=0) → all outputs 0 immediately, without waiting for a clock edge; after release, FSM is IDLE and ignores cfg_valid until start.
